// File: rtl/vga_sync_core.sv
// VGA raster timing generator: pixel-tick divider, free-running x/y counters,
// and registered sync / display-enable / blanked colour so every pin moves on one clk edge.
module vga_sync_core #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic [11:0] rgb_in,
    output logic [11:0] rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        p_tick,
    output logic        frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_MAX        = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX        = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP       = 11'(H_DISPLAY);
    localparam logic [10:0] V_DISP       = 11'(V_DISPLAY);
    localparam logic [10:0] H_SYNC_START = 11'(H_DISPLAY + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_DISPLAY + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_DISPLAY + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      h_cnt_q, h_cnt_d;
    logic [10:0]      v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             tick_raw_s;
    logic             disp_s;

    assign tick_raw_s = (div_q == DIV_MAX);
    // Gating with reset_n keeps the tick low while held in reset even when CLK_DIV is 1.
    assign p_tick      = tick_raw_s && reset_n;
    assign frame_start = p_tick && (h_cnt_q == H_MAX) && (v_cnt_q == V_MAX);
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb_out     = rgb_q;

    // Pixel-tick divider: counts 0..CLK_DIV-1 and wraps.
    always_comb begin
        div_d = div_q;
        if (tick_raw_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Raster counters, advanced only on pixel ticks.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick_raw_s) begin
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = 11'd0;
                if (v_cnt_q == V_MAX) begin
                    v_cnt_d = 11'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 11'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
                v_cnt_d = v_cnt_q;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Pin values decoded from the current counters; registered one clk later.
    always_comb begin
        disp_s     = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
        hsync_d    = ~((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
        vsync_d    = ~((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
        video_on_d = disp_s;
        rgb_d      = 12'h000;
        if (disp_s) begin
            rgb_d = rgb_in;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= {DIV_W{1'b0}};
            h_cnt_q    <= 11'd0;
            v_cnt_q    <= 11'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= 12'h000;
        end else begin
            div_q      <= div_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            rgb_q      <= rgb_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_core.sv
// Directed bench for vga_sync_core: a default-timing instance (line, async reset)
// and a CLK_DIV=1 instance with a tiny raster (whole frames, vsync, frame_start).
module tb_vga_sync_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [11:0] rgb_in;

    logic [10:0] x_a, y_a, x_b, y_b;
    logic [11:0] rgb_out_a, rgb_out_b;
    logic        hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a;
    logic        hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b;

    int n_checks = 0;
    int n_errors = 0;

    vga_sync_core dut_a (
        .clk(clk), .reset_n(rst_a), .x(x_a), .y(y_a), .rgb_in(rgb_in),
        .rgb_out(rgb_out_a), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a), .p_tick(p_tick_a), .frame_start(frame_start_a)
    );

    vga_sync_core #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .reset_n(rst_b), .x(x_b), .y(y_b), .rgb_in(rgb_in),
        .rgb_out(rgb_out_b), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b), .p_tick(p_tick_b), .frame_start(frame_start_b)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {x, y, p_tick, frame_start} n clk edges after reset release.
    function automatic logic [63:0] exp_tim(input int n, input int d, input int ht, input int vt);
        int t, h, v;
        logic p, fs;
        t  = n / d;
        h  = t % ht;
        v  = (t / ht) % vt;
        p  = ((n % d) == (d - 1));
        fs = p && (h == ht - 1) && (v == vt - 1);
        return {40'd0, 11'(h), 11'(v), p, fs};
    endfunction

    // {hsync, vsync, video_on, rgb_out}: pins reflect the counters one edge earlier.
    function automatic logic [63:0] exp_pins(input int n, input int d, input int ht, input int vt,
                                             input int hd, input int hss, input int hse,
                                             input int vd, input int vss, input int vse,
                                             input logic [11:0] rgb);
        int t, h, v;
        logic hs, vs, von;
        if (n == 0) begin
            return {49'd0, 1'b1, 1'b1, 1'b0, 12'h000};
        end
        t   = (n - 1) / d;
        h   = t % ht;
        v   = (t / ht) % vt;
        hs  = !((h >= hss) && (h < hse));
        vs  = !((v >= vss) && (v < vse));
        von = (h < hd) && (v < vd);
        return {49'd0, hs, vs, von, (von ? rgb : 12'h000)};
    endfunction

    function automatic logic [63:0] obs_tim_a();
        return {40'd0, x_a, y_a, p_tick_a, frame_start_a};
    endfunction
    function automatic logic [63:0] obs_pins_a();
        return {49'd0, hsync_a, vsync_a, video_on_a, rgb_out_a};
    endfunction
    function automatic logic [63:0] obs_tim_b();
        return {40'd0, x_b, y_b, p_tick_b, frame_start_b};
    endfunction
    function automatic logic [63:0] obs_pins_b();
        return {49'd0, hsync_b, vsync_b, video_on_b, rgb_out_b};
    endfunction

    task automatic check_a(input int n, input string ph);
        check_val($sformatf("%s_tim n=%0d", ph, n), obs_tim_a(), exp_tim(n, 4, 800, 525));
        check_val($sformatf("%s_pins n=%0d", ph, n), obs_pins_a(),
                  exp_pins(n, 4, 800, 525, 640, 656, 752, 480, 490, 492, rgb_in));
    endtask

    task automatic check_b(input int n);
        check_val($sformatf("b_tim n=%0d", n), obs_tim_b(), exp_tim(n, 1, 15, 8));
        check_val($sformatf("b_pins n=%0d", n), obs_pins_b(),
                  exp_pins(n, 1, 15, 8, 8, 10, 13, 4, 5, 7, rgb_in));
    endtask

    initial begin
        int hs_low, first_tick, vs_low, fs_cnt, hs_low_b;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        rgb_in = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        check_val("a_reset_tim", obs_tim_a(), 64'd0);
        check_val("a_reset_pins", obs_pins_a(), {49'd0, 1'b1, 1'b1, 1'b0, 12'h000});
        check_val("b_reset_tim", obs_tim_b(), 64'd0);
        check_val("b_reset_pins", obs_pins_b(), {49'd0, 1'b1, 1'b1, 1'b0, 12'h000});

        // Default instance: first line plus part of the second.
        rst_a = 1'b1;
        #1;
        check_a(0, "a");
        hs_low     = 0;
        first_tick = -1;
        for (int n = 1; n <= 4401; n++) begin
            @(posedge clk);
            #1;
            check_a(n, "a");
            if (n <= 3200 && hsync_a == 1'b0) hs_low++;
            if (first_tick < 0 && p_tick_a == 1'b1) first_tick = n;
        end
        check_val("a_first_tick_edge", 64'(first_tick), 64'd3);
        check_val("a_hsync_low_clks", 64'(hs_low), 64'd384);
        check_val("a_pre_reset_xy", {42'd0, x_a, y_a}, {42'd0, 11'd300, 11'd1});

        // Asynchronous reset mid-tick at x=300, y=1.
        #2;
        rst_a = 1'b0;
        #1;
        check_val("a_async_tim", obs_tim_a(), 64'd0);
        check_val("a_async_pins", obs_pins_a(), {49'd0, 1'b1, 1'b1, 1'b0, 12'h000});
        repeat (2) @(posedge clk);
        #1;
        check_val("a_held_tim", obs_tim_a(), 64'd0);
        rst_a = 1'b1;
        #1;
        check_a(0, "a_rst");
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            check_a(n, "a_rst");
        end

        // CLK_DIV=1 instance: two full frames of a 15x8 raster.
        rgb_in = 12'h5A3;
        rst_b  = 1'b1;
        #1;
        check_b(0);
        vs_low   = 0;
        fs_cnt   = 0;
        hs_low_b = 0;
        for (int n = 1; n <= 250; n++) begin
            @(posedge clk);
            #1;
            check_b(n);
            if (n <= 120 && vsync_b == 1'b0) vs_low++;
            if (n <= 120 && frame_start_b == 1'b1) fs_cnt++;
            if (n <= 15 && hsync_b == 1'b0) hs_low_b++;
            if (n == 119) check_val("b_fs_xy", {42'd0, x_b, y_b}, {42'd0, 11'd14, 11'd7});
            if (n == 120) check_val("b_wrap_xy", {42'd0, x_b, y_b}, 64'd0);
        end
        check_val("b_vsync_low_clks", 64'(vs_low), 64'd30);
        check_val("b_frame_start_cnt", 64'(fs_cnt), 64'd1);
        check_val("b_hsync_low_clks", 64'(hs_low_b), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_core.md
Name: vga_sync_core

Overview:
- Generates the VGA raster timing that drives the pixel-generation stage: free-running pixel x/y counters, sync pulses and a display-enable.
- Accepts the combinational 12-bit RGB returned by the downstream pixel generator for the current x/y.
- Blanks that RGB and re-times it with hsync/vsync, so all pins leaving the FPGA change on the same clock edge.
- Default timing is 640x480 @ 60 Hz from a 100 MHz system clock, using a 25 MHz pixel-tick enable.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=1; 1 = tick every clock)
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- x  out  11  current horizontal pixel count (to pixel generator)
- y  out  11  current vertical line count (to pixel generator)
- rgb_in  in  12  {b,g,r} colour for current x/y from pixel generator
- rgb_out  out  12  blanked, registered colour to VGA pins
- hsync  out  1  horizontal sync, active low, registered
- vsync  out  1  vertical sync, active low, registered
- video_on  out  1  registered display-enable, aligned with rgb_out
- p_tick  out  1  pixel-tick enable, one clk wide
- frame_start  out  1  one-clk pulse on the last pixel tick of a frame

Behaviour:
- Reset is asynchronous, active-low, one clock. It is asserted asynchronously and takes effect immediately, including mid-line or mid-frame. On reset:
  - divider, h_cnt and v_cnt = 0
  - hsync = 1, vsync = 1
  - video_on = 0, rgb_out = 12'h000
  - p_tick = 0, frame_start = 0
- Derived totals: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), combinational from the register.
  - With CLK_DIV=1, p_tick = 1 every clock after reset release.
- Counters advance only in cycles with p_tick = 1:
  - If h_cnt == H_TOTAL-1, then h_cnt <= 0.
  - If also v_cnt == V_TOTAL-1, then v_cnt <= 0; otherwise v_cnt <= v_cnt+1.
  - Otherwise h_cnt <= h_cnt+1 and v_cnt holds.
  - Counters never exceed TOTAL-1.
- x = h_cnt and y = v_cnt, driven directly from the registers and zero-extended to 11 bits.
- frame_start = p_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1 (combinational).
- Registered outputs update every clk, one clk after the counter values they reflect. This gives a fixed 1-clk latency from x/y (and rgb_in) to pins.
  - hsync <= ~(h_cnt >= H_DISPLAY+H_FP && h_cnt < H_DISPLAY+H_FP+H_SYNC), i.e. low for h 656..751.
  - vsync <= ~(v_cnt >= V_DISPLAY+V_FP && v_cnt < V_DISPLAY+V_FP+V_SYNC), i.e. low for v 490..491.
  - video_on <= (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - rgb_out <= video_on condition ? rgb_in : 12'h000. The same comparison is used, so rgb_out is always black in blanking.
- rgb_in is sampled every clk. Because x/y are stable for CLK_DIV clocks, the downstream combinational generator has a full clock to settle.
- No handshake; the block free-runs from reset release. There is no back-pressure and no stall.

Test Plan:
- Reset release with default params -> all outputs at reset values; first p_tick at clk 4 after release; p_tick period exactly 4 clks, width 1.
- Run one line -> x steps 0..799, then 0; y increments 0 -> 1 on the p_tick where x wraps; hsync low for exactly 96 pixel ticks (x 656..751 delayed 1 clk); hsync is 1 otherwise.
- Run full frame -> vsync low for exactly 2 lines (y 490..491); frame_start pulses once, with x=799, y=524; the next tick gives x=0, y=0; frame = 420000 pixel ticks.
- Drive rgb_in = 12'hABC constant -> rgb_out = 12'hABC when x<640 && y<480 (1 clk later), and 12'h000 at x=640..799 and y>=480; video_on toggles identically.
- Assert reset_n low at x=300, y=200, mid-tick -> outputs go to reset values immediately, without waiting for a clk edge; after release, counting restarts at x=0, y=0 with the divider restarted.
- CLK_DIV=1 build -> p_tick constantly 1; x advances every clk; sync widths in clocks equal the pixel counts.
